// File: rtl/icache_direct_mapped_if.sv
// icache_direct_mapped_if: fetch-port, memory-port and counter signals of the instruction cache
interface icache_direct_mapped_if #(parameter int W = 32);
  logic         imemREN;
  logic [W-1:0] imemaddr;
  logic         ihit;
  logic [W-1:0] imemload;
  logic         iREN;
  logic [W-1:0] iaddr;
  logic         iwait;
  logic [W-1:0] iload;
  logic [W-1:0] hit_count;
  logic [W-1:0] miss_count;
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped single-word-frame instruction cache with miss FSM and perf counters
module icache_direct_mapped #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input logic                    CLK,
  input logic                    nRST,
  icache_direct_mapped_if.slave  bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t              state_q, state_d;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [WORD_W-1:0]   data_q [SETS];
  logic [WORD_W-1:0]   miss_addr_q, hit_cnt_q, miss_cnt_q;
  logic [IDX_W-1:0]    idx, fidx;
  logic [TAG_W-1:0]    tag, ftag;
  logic                hit, miss, fill;
  assign idx  = bus.imemaddr[IDX_W+1:2];
  assign tag  = bus.imemaddr[WORD_W-1:IDX_W+2];
  assign fidx = miss_addr_q[IDX_W+1:2];
  assign ftag = miss_addr_q[WORD_W-1:IDX_W+2];
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
  // lookup in IDLE, memory request in FETCH; fill completes on the first edge with iwait low
  always_comb begin
    state_d      = state_q;
    hit          = 1'b0;
    miss         = 1'b0;
    fill         = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    if (state_q == IDLE) begin
      hit          = bus.imemREN & valid_q[idx] & (tag_q[idx] == tag);
      miss         = bus.imemREN & ~hit;
      bus.ihit     = hit;
      bus.imemload = hit ? data_q[idx] : '0;
      state_d      = miss ? FETCH : IDLE;
    end else begin
      bus.iREN  = 1'b1;
      bus.iaddr = miss_addr_q;
      fill      = ~bus.iwait;
      state_d   = bus.iwait ? FETCH : IDLE;
    end
  end
  // state, frame array, latched miss address and saturating counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (miss) miss_addr_q <= {bus.imemaddr[WORD_W-1:2], 2'b00};
      if (miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      if (hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (fill) begin
        valid_q[fidx] <= 1'b1;
        tag_q[fidx]   <= ftag;
        data_q[fidx]  <= bus.iload;
      end
    end
  end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: directed self-checking bench for the direct-mapped instruction cache
module tb_icache_direct_mapped;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  icache_direct_mapped_if bus ();
  icache_direct_mapped dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    bus.imemREN = 1'b0; bus.imemaddr = 32'h40; bus.iwait = 1'b1; bus.iload = '0;
    nRST = 1'b0;
    tick();
    tick();
    n_chk++; if (bus.ihit !== 1'b0) $display("FAIL reset_ihit got %h exp 0", bus.ihit); else n_pass++;
    n_chk++; if (bus.iREN !== 1'b0) $display("FAIL reset_iREN got %h exp 0", bus.iREN); else n_pass++;
    n_chk++; if (bus.iaddr !== 32'h0) $display("FAIL reset_iaddr got %h exp 0", bus.iaddr); else n_pass++;
    n_chk++; if (bus.imemload !== 32'h0) $display("FAIL reset_imemload got %h exp 0", bus.imemload); else n_pass++;
    n_chk++; if (bus.hit_count !== 32'h0) $display("FAIL reset_hits got %h exp 0", bus.hit_count); else n_pass++;
    n_chk++; if (bus.miss_count !== 32'h0) $display("FAIL reset_misses got %h exp 0", bus.miss_count); else n_pass++;
    nRST = 1'b1;
    tick();
  endtask
  // drives one full miss with nwait busy cycles, leaving the bench on the first IDLE cycle after the fill
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] exp_iaddr, input logic [31:0] data, input int nwait);
    bus.imemREN = 1'b1; bus.imemaddr = addr; bus.iwait = 1'b1;
    #1;
    n_chk++; if (bus.ihit !== 1'b0) $display("FAIL miss_lookup_%h got ihit %h exp 0", addr, bus.ihit); else n_pass++;
    tick();
    for (int k = 0; k <= nwait; k++) begin
      bus.iwait = (k < nwait); bus.iload = data;
      #1;
      n_chk++; if (bus.iREN !== 1'b1 || bus.iaddr !== exp_iaddr || bus.ihit !== 1'b0)
        $display("FAIL fetch_%h_c%0d got iREN %h iaddr %h ihit %h exp 1 %h 0", addr, k, bus.iREN, bus.iaddr, bus.ihit, exp_iaddr);
      else n_pass++;
      tick();
    end
    bus.iwait = 1'b1; bus.iload = '0;
    #1;
    n_chk++; if (bus.ihit !== 1'b1 || bus.imemload !== data || bus.iREN !== 1'b0)
      $display("FAIL refill_hit_%h got ihit %h load %h iREN %h exp 1 %h 0", addr, bus.ihit, bus.imemload, bus.iREN, data);
    else n_pass++;
  endtask
  task automatic test_cold_miss();
    do_miss(32'h40, 32'h40, 32'h0010_0093, 3);
    n_chk++; if (bus.miss_count !== 32'd1) $display("FAIL cold_misses got %0d exp 1", bus.miss_count); else n_pass++;
    tick();
    n_chk++; if (bus.hit_count !== 32'd1) $display("FAIL cold_hits got %0d exp 1", bus.hit_count); else n_pass++;
  endtask
  task automatic test_repeated_hit();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (bus.ihit !== 1'b1 || bus.iREN !== 1'b0 || bus.imemload !== 32'h0010_0093)
        $display("FAIL rep_hit_%0d got ihit %h iREN %h load %h exp 1 0 00100093", i, bus.ihit, bus.iREN, bus.imemload);
      else n_pass++;
      tick();
    end
    bus.imemREN = 1'b0;
    n_chk++; if (bus.hit_count !== 32'd6) $display("FAIL rep_hits got %0d exp 6", bus.hit_count); else n_pass++;
  endtask
  task automatic test_idle_offset();
    bus.imemREN = 1'b0; bus.imemaddr = 32'h40;
    #1;
    n_chk++; if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0) $display("FAIL idle_ihit got ihit %h iREN %h exp 0 0", bus.ihit, bus.iREN); else n_pass++;
    tick();
    tick();
    n_chk++; if (bus.hit_count !== 32'd6 || bus.miss_count !== 32'd1)
      $display("FAIL idle_counts got %0d %0d exp 6 1", bus.hit_count, bus.miss_count);
    else n_pass++;
    bus.imemREN = 1'b1; bus.imemaddr = 32'h43;
    #1;
    n_chk++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'h0010_0093)
      $display("FAIL offset_hit got ihit %h load %h exp 1 00100093", bus.ihit, bus.imemload);
    else n_pass++;
    bus.imemREN = 1'b0;
    tick();
  endtask
  task automatic test_conflict();
    do_miss(32'h80, 32'h80, 32'hDEAD_BEEF, 0);
    bus.imemREN = 1'b0;
    tick();
    do_miss(32'h40, 32'h40, 32'h1111_2222, 1);
    n_chk++; if (bus.miss_count !== 32'd3) $display("FAIL conflict_misses got %0d exp 3", bus.miss_count); else n_pass++;
    bus.imemREN = 1'b0;
    tick();
  endtask
  task automatic test_redirect();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h100; bus.iwait = 1'b1;
    tick();
    bus.imemaddr = 32'h200;
    #1;
    n_chk++; if (bus.iaddr !== 32'h100 || bus.iREN !== 1'b1) $display("FAIL redir_iaddr0 got %h exp 100", bus.iaddr); else n_pass++;
    tick();
    bus.iwait = 1'b0; bus.iload = 32'hAAAA_0100;
    #1;
    n_chk++; if (bus.iaddr !== 32'h100 || bus.ihit !== 1'b0) $display("FAIL redir_iaddr1 got %h ihit %h exp 100 0", bus.iaddr, bus.ihit); else n_pass++;
    tick();
    bus.iwait = 1'b1; bus.iload = '0; bus.imemaddr = 32'h100;
    #1;
    n_chk++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'hAAAA_0100)
      $display("FAIL redir_fill100 got ihit %h load %h exp 1 aaaa0100", bus.ihit, bus.imemload);
    else n_pass++;
    bus.imemaddr = 32'h200;
    #1;
    n_chk++; if (bus.ihit !== 1'b0) $display("FAIL redir_miss200 got ihit %h exp 0", bus.ihit); else n_pass++;
    tick();
    n_chk++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h200) $display("FAIL redir_iaddr200 got iREN %h iaddr %h exp 1 200", bus.iREN, bus.iaddr); else n_pass++;
    n_chk++; if (bus.miss_count !== 32'd5) $display("FAIL redir_misses got %0d exp 5", bus.miss_count); else n_pass++;
    bus.iwait = 1'b0; bus.iload = 32'hBBBB_0200;
    tick();
    bus.iwait = 1'b1;
    #1;
    n_chk++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'hBBBB_0200)
      $display("FAIL redir_hit200 got ihit %h load %h exp 1 bbbb0200", bus.ihit, bus.imemload);
    else n_pass++;
    bus.imemREN = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid_fill();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h300; bus.iwait = 1'b1;
    tick();
    #1;
    n_chk++; if (bus.iREN !== 1'b1) $display("FAIL rmf_fetch got iREN %h exp 1", bus.iREN); else n_pass++;
    #2;
    nRST = 1'b0;
    #1;
    n_chk++; if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) $display("FAIL rmf_abort got iREN %h iaddr %h exp 0 0", bus.iREN, bus.iaddr); else n_pass++;
    bus.iwait = 1'b0; bus.iload = 32'hCCCC_0300;
    tick();
    bus.iwait = 1'b1;
    nRST = 1'b1;
    #1;
    n_chk++; if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0)
      $display("FAIL rmf_counts got %0d %0d exp 0 0", bus.hit_count, bus.miss_count);
    else n_pass++;
    n_chk++; if (bus.ihit !== 1'b0) $display("FAIL rmf_remiss got ihit %h exp 0", bus.ihit); else n_pass++;
    tick();
    n_chk++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h300 || bus.miss_count !== 32'd1)
      $display("FAIL rmf_refetch got iREN %h iaddr %h misses %0d exp 1 300 1", bus.iREN, bus.iaddr, bus.miss_count);
    else n_pass++;
    bus.iwait = 1'b0; bus.iload = 32'hCCCC_0300;
    tick();
    bus.iwait = 1'b1;
    #1;
    n_chk++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'hCCCC_0300)
      $display("FAIL rmf_hit got ihit %h load %h exp 1 cccc0300", bus.ihit, bus.imemload);
    else n_pass++;
    bus.imemREN = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_cold_miss();
    test_repeated_hit();
    test_idle_offset();
    test_conflict();
    test_redirect();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
